// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D cache memory-port arbiter.
package mem_arb_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = IDLE,
    S_GRANT_I = GRANT_I,
    S_GRANT_D = GRANT_D,
    S_RELEASE = RELEASE
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals of the arbiter.
// Handshake: a requester raises enable with write/addr/data stable and holds it
// until it sees a one-cycle ack; the ack alone qualifies the read data.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_enable_i;
  logic              i_write_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic [LINE_W-1:0] i_data_i;
  logic              i_ack_o;
  logic [LINE_W-1:0] i_data_o;
  logic              d_enable_i;
  logic              d_write_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [LINE_W-1:0] d_data_i;
  logic              d_ack_o;
  logic [LINE_W-1:0] d_data_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_i;
  logic              busy_o;
  logic              err_o;
  logic [1:0]        dbg_state_o;

  // slave = the arbiter itself; master = caches and memory around it
  modport slave (
    input  i_enable_i, i_write_i, i_addr_i, i_data_i,
    input  d_enable_i, d_write_i, d_addr_i, d_data_i,
    input  mem_ack_i, mem_data_i,
    output i_ack_o, i_data_o, d_ack_o, d_data_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output busy_o, err_o, dbg_state_o
  );

  modport master (
    output i_enable_i, i_write_i, i_addr_i, i_data_i,
    output d_enable_i, d_write_i, d_addr_i, d_data_i,
    output mem_ack_i, mem_data_i,
    input  i_ack_o, i_data_o, d_ack_o, d_data_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  busy_o, err_o, dbg_state_o
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Grant watchdog: clears between grants, counts un-acked grant cycles and
// flags the cycle in which the count would reach TIMEOUT (0 disables it).
module mem_arb_watchdog #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_timeout = (TIMEOUT != 0) && i_inc && (r_cnt == LP_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 256-bit line memory port between the
// instruction and data caches, with a one-cycle release gap and a watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);

  state_t r_state;
  state_t w_next;
  logic   r_last_grant;
  logic   w_last_next;
  logic   r_err;
  logic   w_set_err;
  logic   w_busy;
  logic   w_sel_d;
  logic   w_req_en;
  logic   w_timeout;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_last_grant <= REQ_I;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_last_grant <= w_last_next;
      r_err        <= r_err | w_set_err;
    end
  end

  assign w_busy   = (r_state == S_GRANT_I) || (r_state == S_GRANT_D);
  assign w_sel_d  = (r_state == S_GRANT_D);
  assign w_req_en = w_sel_d ? bus.d_enable_i : bus.i_enable_i;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_clr     (!w_busy),
    .i_inc     (w_busy && !bus.mem_ack_i),
    .o_timeout (w_timeout)
  );

  always_comb begin
    w_next      = r_state;
    w_last_next = r_last_grant;
    w_set_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (bus.i_enable_i && bus.d_enable_i) begin
          if (r_last_grant == REQ_I) begin
            w_next      = S_GRANT_D;
            w_last_next = REQ_D;
          end else begin
            w_next      = S_GRANT_I;
            w_last_next = REQ_I;
          end
        end else if (bus.i_enable_i) begin
          w_next      = S_GRANT_I;
          w_last_next = REQ_I;
        end else if (bus.d_enable_i) begin
          w_next      = S_GRANT_D;
          w_last_next = REQ_D;
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        if (bus.mem_ack_i || !w_req_en) begin
          w_next = S_RELEASE;
        end else if (w_timeout) begin
          w_next    = S_RELEASE;
          w_set_err = 1'b1;
        end
      end
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = {ADDR_W{1'b0}};
    bus.mem_data_o   = {LINE_W{1'b0}};
    bus.i_ack_o      = 1'b0;
    bus.d_ack_o      = 1'b0;
    if (w_busy) begin
      bus.mem_enable_o = w_req_en;
      bus.mem_write_o  = w_req_en & (w_sel_d ? bus.d_write_i : bus.i_write_i);
      bus.mem_addr_o   = w_sel_d ? bus.d_addr_i : bus.i_addr_i;
      bus.mem_data_o   = w_sel_d ? bus.d_data_i : bus.i_data_i;
      bus.i_ack_o      = !w_sel_d & bus.mem_ack_i;
      bus.d_ack_o      = w_sel_d & bus.mem_ack_i;
    end
  end

  assign bus.i_data_o    = bus.mem_data_i;
  assign bus.d_data_o    = bus.mem_data_i;
  assign bus.busy_o      = w_busy;
  assign bus.err_o       = r_err;
  assign bus.dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model of both arbiter
// instances is compared every cycle, plus hand-computed literal expectations.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus_a ();
  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus_w ();

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(1023), .CNT_W(10)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(8), .CNT_W(4)) dut_w (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_w)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          ie;
    logic          iw;
    logic [AW-1:0] ia;
    logic [LW-1:0] idat;
    logic          de;
    logic          dw;
    logic [AW-1:0] da;
    logic [LW-1:0] ddat;
    logic          ack;
  } in_t;

  // ctrl = {mem_en, mem_wr, i_ack, d_ack, busy, err, state[1:0]}
  typedef struct packed {
    logic [7:0]    ctrl;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdat;
  } out_t;

  in_t  in_a, in_w;
  out_t out_a, out_w;

  always_comb begin
    in_a.ie = bus_a.i_enable_i; in_a.iw = bus_a.i_write_i;
    in_a.ia = bus_a.i_addr_i;   in_a.idat = bus_a.i_data_i;
    in_a.de = bus_a.d_enable_i; in_a.dw = bus_a.d_write_i;
    in_a.da = bus_a.d_addr_i;   in_a.ddat = bus_a.d_data_i;
    in_a.ack = bus_a.mem_ack_i;
    in_w.ie = bus_w.i_enable_i; in_w.iw = bus_w.i_write_i;
    in_w.ia = bus_w.i_addr_i;   in_w.idat = bus_w.i_data_i;
    in_w.de = bus_w.d_enable_i; in_w.dw = bus_w.d_write_i;
    in_w.da = bus_w.d_addr_i;   in_w.ddat = bus_w.d_data_i;
    in_w.ack = bus_w.mem_ack_i;
  end

  always_comb begin
    out_a.ctrl = {bus_a.mem_enable_o, bus_a.mem_write_o, bus_a.i_ack_o, bus_a.d_ack_o,
                  bus_a.busy_o, bus_a.err_o, bus_a.dbg_state_o};
    out_a.addr = bus_a.mem_addr_o;
    out_a.wdat = bus_a.mem_data_o;
    out_w.ctrl = {bus_w.mem_enable_o, bus_w.mem_write_o, bus_w.i_ack_o, bus_w.d_ack_o,
                  bus_w.busy_o, bus_w.err_o, bus_w.dbg_state_o};
    out_w.addr = bus_w.mem_addr_o;
    out_w.wdat = bus_w.mem_data_o;
  end

  // owner: 0 none, 1 I, 2 D; age = grant cycles already completed
  int m_owner[2];
  int m_last[2];
  int m_age[2];
  int m_tmo[2];
  bit m_rel[2];
  bit m_err[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 0;
      m_last[k]  = 1;
      m_age[k]   = 0;
      m_rel[k]   = 1'b0;
      m_err[k]   = 1'b0;
    end
    m_tmo[0] = 1023;
    m_tmo[1] = 8;
  endtask

  function automatic out_t model_out(int k, in_t x);
    out_t o;
    logic en, wr, ack_i, ack_d, busy;
    logic [1:0] st;
    o = '0; en = 1'b0; wr = 1'b0; ack_i = 1'b0; ack_d = 1'b0; busy = 1'b0; st = 2'd0;
    if (m_owner[k] == 1) begin
      busy = 1'b1; en = x.ie; wr = x.ie & x.iw; ack_i = x.ack; st = 2'd1;
      o.addr = x.ia; o.wdat = x.idat;
    end else if (m_owner[k] == 2) begin
      busy = 1'b1; en = x.de; wr = x.de & x.dw; ack_d = x.ack; st = 2'd2;
      o.addr = x.da; o.wdat = x.ddat;
    end else if (m_rel[k]) begin
      st = 2'd3;
    end
    o.ctrl = {en, wr, ack_i, ack_d, busy, m_err[k], st};
    return o;
  endfunction

  task automatic model_step(int k, in_t x);
    bit en, tmo;
    if (m_owner[k] != 0) begin
      en  = (m_owner[k] == 1) ? x.ie : x.de;
      tmo = (m_tmo[k] != 0) && (m_age[k] + 1 >= m_tmo[k]);
      if (x.ack || !en || tmo) begin
        if (!x.ack && en && tmo) m_err[k] = 1'b1;
        m_owner[k] = 0;
        m_rel[k]   = 1'b1;
      end else begin
        m_age[k]++;
      end
    end else if (m_rel[k]) begin
      m_rel[k] = 1'b0;
    end else begin
      if (x.ie && x.de) m_owner[k] = (m_last[k] == 2) ? 1 : 2;
      else if (x.ie)    m_owner[k] = 1;
      else if (x.de)    m_owner[k] = 2;
      if (m_owner[k] != 0) begin
        m_last[k] = m_owner[k];
        m_age[k]  = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else begin
        model_step(0, in_a);
        model_step(1, in_w);
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  task automatic cmp(input string tag, input out_t act, input out_t exp,
                     input logic [LW-1:0] rd_i, input logic [LW-1:0] rd_d,
                     input logic [LW-1:0] rd_m);
    chk({tag, "_ctrl"}, LW'(act.ctrl), LW'(exp.ctrl));
    chk({tag, "_addr"}, LW'(act.addr), LW'(exp.addr));
    chk({tag, "_wdata"}, act.wdat, exp.wdat);
    chk({tag, "_rdata_i"}, rd_i, rd_m);
    chk({tag, "_rdata_d"}, rd_d, rd_m);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp("cyc_a", out_a, model_out(0, in_a), bus_a.i_data_o, bus_a.d_data_o, bus_a.mem_data_i);
      cmp("cyc_w", out_w, model_out(1, in_w), bus_w.i_data_o, bus_w.d_data_o, bus_w.mem_data_i);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Called in the IDLE cycle where the request is visible; returns in the
  // IDLE cycle after RELEASE.
  task automatic grant_seq(input string tag, input bit is_d, input logic [AW-1:0] addr,
                           input logic wr, input logic [LW-1:0] wdat, input int lat,
                           input logic [LW-1:0] rdat, input bit stray);
    cyc();
    chk({tag, "_state"}, LW'(bus_a.dbg_state_o), is_d ? 256'd2 : 256'd1);
    chk({tag, "_en"}, LW'(bus_a.mem_enable_o), LW'(1));
    chk({tag, "_addr"}, LW'(bus_a.mem_addr_o), LW'(addr));
    chk({tag, "_wr"}, LW'(bus_a.mem_write_o), LW'(wr));
    if (wr) chk({tag, "_wdata"}, bus_a.mem_data_o, wdat);
    repeat (lat - 1) cyc();
    bus_a.mem_ack_i  = 1'b1;
    bus_a.mem_data_i = rdat;
    #1;
    chk({tag, "_ack_own"}, LW'(is_d ? bus_a.d_ack_o : bus_a.i_ack_o), LW'(1));
    chk({tag, "_ack_other"}, LW'(is_d ? bus_a.i_ack_o : bus_a.d_ack_o), LW'(0));
    chk({tag, "_rdata"}, is_d ? bus_a.d_data_o : bus_a.i_data_o, rdat);
    cyc();
    bus_a.mem_ack_i = stray;
    if (is_d) begin bus_a.d_enable_i = 1'b0; bus_a.d_write_i = 1'b0; end
    else      begin bus_a.i_enable_i = 1'b0; bus_a.i_write_i = 1'b0; end
    #1;
    chk({tag, "_rel_state"}, LW'(bus_a.dbg_state_o), LW'(3));
    chk({tag, "_rel_en"}, LW'(bus_a.mem_enable_o), LW'(0));
    chk({tag, "_rel_acks"}, LW'({bus_a.i_ack_o, bus_a.d_ack_o}), LW'(0));
    cyc();
    bus_a.mem_ack_i = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [LW-1:0] line_a5;

  initial begin
    line_a5 = {32{8'hA5}};
    bus_a.i_enable_i = 0; bus_a.i_write_i = 0; bus_a.i_addr_i = '0; bus_a.i_data_i = '0;
    bus_a.d_enable_i = 0; bus_a.d_write_i = 0; bus_a.d_addr_i = '0; bus_a.d_data_i = '0;
    bus_a.mem_ack_i  = 0; bus_a.mem_data_i = '0;
    bus_w.i_enable_i = 0; bus_w.i_write_i = 0; bus_w.i_addr_i = '0; bus_w.i_data_i = '0;
    bus_w.d_enable_i = 0; bus_w.d_write_i = 0; bus_w.d_addr_i = '0; bus_w.d_data_i = '0;
    bus_w.mem_ack_i  = 0; bus_w.mem_data_i = '0;

    do_reset();
    chk("rst_ctrl_a", LW'(out_a.ctrl), LW'(0));
    chk("rst_ctrl_w", LW'(out_w.ctrl), LW'(0));

    // Single D read, ack on the 10th grant cycle
    bus_a.d_enable_i = 1; bus_a.d_addr_i = 32'h0000_0400;
    #1;
    chk("t1_en_before_grant", LW'(bus_a.mem_enable_o), LW'(0));
    grant_seq("t1", 1'b1, 32'h0000_0400, 1'b0, '0, 10, {8{32'hDEAD_BEEF}}, 1'b1);
    // stray ack in IDLE
    bus_a.mem_ack_i = 1;
    #1;
    chk("t1_stray_idle_acks", LW'({bus_a.i_ack_o, bus_a.d_ack_o}), LW'(0));
    cyc();
    bus_a.mem_ack_i = 0;
    chk("t1_stray_idle_state", LW'(bus_a.dbg_state_o), LW'(0));

    // Simultaneous requests: D first after reset, then I, then alternating
    do_reset();
    bus_a.i_enable_i = 1; bus_a.i_addr_i = 32'h0000_1000;
    bus_a.d_enable_i = 1; bus_a.d_addr_i = 32'h0000_2000;
    grant_seq("t2a", 1'b1, 32'h0000_2000, 1'b0, '0, 1, {8{32'h1111_2222}}, 1'b0);
    chk("t2_gap_state", LW'(bus_a.dbg_state_o), LW'(0));
    chk("t2_gap_en", LW'(bus_a.mem_enable_o), LW'(0));
    grant_seq("t2b", 1'b0, 32'h0000_1000, 1'b0, '0, 2, {8{32'h3333_4444}}, 1'b0);
    bus_a.i_enable_i = 1; bus_a.d_enable_i = 1;
    grant_seq("t2c", 1'b1, 32'h0000_2000, 1'b0, '0, 3, {8{32'h5555_6666}}, 1'b0);
    grant_seq("t2d", 1'b0, 32'h0000_1000, 1'b0, '0, 1, {8{32'h7777_8888}}, 1'b0);

    // Dirty miss: D write-back, pending I goes next, then D re-read
    do_reset();
    bus_a.i_enable_i = 1; bus_a.i_addr_i = 32'h0000_1040;
    bus_a.d_enable_i = 1; bus_a.d_write_i = 1; bus_a.d_addr_i = 32'h0000_3000;
    bus_a.d_data_i = line_a5;
    grant_seq("t3w", 1'b1, 32'h0000_3000, 1'b1, line_a5, 3, '0, 1'b0);
    bus_a.d_enable_i = 1; bus_a.d_write_i = 0;
    grant_seq("t3i", 1'b0, 32'h0000_1040, 1'b0, '0, 2, {8{32'hCAFE_F00D}}, 1'b0);
    grant_seq("t3r", 1'b1, 32'h0000_3000, 1'b0, '0, 2, {8{32'h0BAD_CAFE}}, 1'b0);

    // Watchdog on the TIMEOUT=8 instance: memory never acks
    bus_w.i_enable_i = 1; bus_w.i_addr_i = 32'h0000_0800;
    cyc();
    chk("t4_grant_state", LW'(bus_w.dbg_state_o), LW'(1));
    repeat (7) cyc();
    chk("t4_cycle8_en", LW'(bus_w.mem_enable_o), LW'(1));
    chk("t4_cycle8_err", LW'(bus_w.err_o), LW'(0));
    cyc();
    chk("t4_err_set", LW'(bus_w.err_o), LW'(1));
    chk("t4_en_dropped", LW'(bus_w.mem_enable_o), LW'(0));
    chk("t4_no_ack", LW'(bus_w.i_ack_o), LW'(0));
    chk("t4_release", LW'(bus_w.dbg_state_o), LW'(3));
    bus_w.i_enable_i = 0;
    repeat (5) cyc();
    chk("t4_err_sticky", LW'(bus_w.err_o), LW'(1));
    do_reset();
    chk("t4_err_cleared", LW'(bus_w.err_o), LW'(0));

    // Asynchronous reset in the middle of a D grant
    bus_a.d_enable_i = 1; bus_a.d_addr_i = 32'h0000_5000;
    cyc();
    cyc();
    chk("t5_grant_d", LW'(bus_a.dbg_state_o), LW'(2));
    #2;
    rst = 0;
    bus_a.mem_ack_i = 1;
    bus_a.i_enable_i = 1; bus_a.i_addr_i = 32'h0000_6000;
    #1;
    chk("t5_async_en", LW'(bus_a.mem_enable_o), LW'(0));
    chk("t5_async_busy", LW'(bus_a.busy_o), LW'(0));
    chk("t5_async_acks", LW'({bus_a.i_ack_o, bus_a.d_ack_o}), LW'(0));
    chk("t5_async_state", LW'(bus_a.dbg_state_o), LW'(0));
    @(posedge clk);
    #1;
    bus_a.mem_ack_i = 0;
    rst = 1;
    grant_seq("t5_tie", 1'b1, 32'h0000_5000, 1'b0, '0, 2, {8{32'h1234_5678}}, 1'b0);
    grant_seq("t5_then_i", 1'b0, 32'h0000_6000, 1'b0, '0, 1, {8{32'h8765_4321}}, 1'b0);

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end within 200000 time units");
    $fatal(1, "bench timeout");
  end

endmodule
